// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// width helpers used to size grant indices and the beat counter.
package fifo_arb_pkg;

    // Arbiter FSM states: waiting for a request, or streaming a granted burst.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idw_f(input int unsigned n);
        return (n <= 2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Beat counter width: must hold the value BURST itself.
    function automatic int unsigned cnt_w_f(input int unsigned burst);
        return 32'($clog2(burst)) + 32'd1;
    endfunction

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin picker: scans upward from last_grant+1 (wrapping modulo NREQ)
// and reports the first asserted request.
//   req        - request vector, one bit per requester
//   last_grant - index of the previously served requester
//   valid      - at least one request present
//   index      - winning requester index (0 when valid is low)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic            valid,
    output logic [IDW-1:0]  index
);

    // Offset 1 is checked first so the last winner has lowest priority.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        valid = 1'b0;
        index = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_grant) + k) % NREQ;
            if (!valid && req[IDW'(idx)]) begin
                valid = 1'b1;
                index = IDW'(idx);
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a FIFO write port. A requester is
// granted for a burst of up to BURST beats; the burst ends early on an
// almost-full write or when the granted requester drops valid. The FIFO
// strobe and ready are combinational so back-pressure acts in the same cycle.
//
// Optional build macro FIFO_WR_ARB_TAG_EN: prefix fifo_wdata with grant_id.
//
// Ports:
//   wclk, wrst_n  - clock, asynchronous active-low reset
//   req_valid     - per-requester word valid
//   req_data      - packed payloads, requester i at [i*DSIZE +: DSIZE]
//   req_ready     - accept to the granted requester (one-hot or zero)
//   fifo_winc     - FIFO write strobe
//   fifo_wdata    - FIFO write data ({grant_id, payload} when tagged)
//   fifo_wfull    - FIFO full
//   fifo_awfull   - FIFO almost full
//   grant_id      - currently granted requester
//   busy          - burst in progress
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned DSIZE = 32,
    parameter  int unsigned BURST = 4,
    localparam int unsigned IDW   = idw_f(NREQ),
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int unsigned DW    = DSIZE + IDW
`else
    localparam int unsigned DW    = DSIZE
`endif
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_winc,
    output logic [DW-1:0]         fifo_wdata,
    input  logic                  fifo_wfull,
    input  logic                  fifo_awfull,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int unsigned CW = cnt_w_f(BURST);

    arb_state_e       state, state_nxt;
    logic [IDW-1:0]   last_grant, last_nxt, grant_nxt;
    logic [CW-1:0]    beat_cnt, beat_nxt, beat_inc;
    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic             gnt_valid;
    logic             xfer;
    logic [DSIZE-1:0] lane [NREQ];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    // Unpack requester payloads for indexed selection.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            lane[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    assign gnt_valid = req_valid[grant_id];
    assign xfer      = (state == ST_BURST) && gnt_valid && !fifo_wfull;
    assign beat_inc  = beat_cnt + CW'(1);

    // Next-state: arbitrate in IDLE, count beats and detect burst end in BURST.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        beat_nxt  = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_valid && !fifo_wfull) begin
                    state_nxt = ST_BURST;
                    grant_nxt = pick_idx;
                    beat_nxt  = '0;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    beat_nxt = beat_inc;
                end
                if (!gnt_valid || (xfer && (beat_inc == CW'(BURST) || fifo_awfull))) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = grant_id;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset leaves requester 0 first in line.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(NREQ - 1);
            beat_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= beat_nxt;
            busy       <= (state_nxt == ST_BURST);
        end
    end

    // Write-side outputs follow fifo_wfull within the cycle.
    assign fifo_winc = xfer;
    assign req_ready = ((state == ST_BURST) && !fifo_wfull) ? (NREQ'(1) << grant_id) : '0;

`ifdef FIFO_WR_ARB_TAG_EN
    assign fifo_wdata = {grant_id, lane[grant_id]};
`else
    assign fifo_wdata = lane[grant_id];
`endif

endmodule : fifo_wr_arb

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter DSIZE, default 32: payload width per requester.
REQ-003 SHALL have parameter BURST, default 4: maximum beats per grant (1..16).
REQ-004 SHALL have port wclk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port wrst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ: per-requester word valid.
REQ-007 SHALL have port req_data  input  NREQ*DSIZE: requester i occupies bits [i*DSIZE +: DSIZE].
REQ-008 SHALL have port req_ready  output  NREQ: per-requester accept; one-hot or zero.
REQ-009 SHALL have port fifo_winc  output  1: write strobe to the FIFO write port.
REQ-010 SHALL have port fifo_wdata  output  DW: FIFO write data; DW per REQ-027.
REQ-011 SHALL have port fifo_wfull  input  1: FIFO full.
REQ-012 SHALL have port fifo_awfull  input  1: FIFO almost full.
REQ-013 SHALL have port grant_id  output  IDW=$clog2(NREQ): currently granted requester.
REQ-014 SHALL have port busy  output  1: high while in state BURST.

Function
REQ-015 SHALL implement FSM states IDLE and BURST.
- IDLE: no req_ready, fifo_winc low.
- IDLE->BURST: |req_valid and !fifo_wfull; winner latched into grant_id; 1-cycle arbitration latency, no data moves in IDLE.
REQ-016 SHALL select round-robin: scan from last_grant+1 upward, modulo NREQ, first valid wins.
REQ-017 SHALL in BURST drive req_ready[grant_id] = !fifo_wfull, all other ready bits low.
REQ-018 SHALL in BURST drive fifo_winc = req_valid[grant_id] & !fifo_wfull (combinational); fifo_wdata = req_data of grant_id.
REQ-019 SHALL count beats (transfer = fifo_winc high) in a counter of $clog2(BURST)+1 bits, cleared on entry to BURST.
REQ-020 SHALL return BURST->IDLE and set last_grant=grant_id when any of the following holds:
- a transfer is the BURST-th beat;
- a transfer occurs with fifo_awfull high;
- req_valid[grant_id] is low (no transfer, burst abandoned).
REQ-021 SHALL never assert fifo_winc while fifo_wfull is high.
REQ-022 SHALL keep state BURST with no transfer while fifo_wfull is high and req_valid[grant_id] is high (stall, no beat counted).
REQ-023 SHALL, when BURST=1, end every burst after one transfer.

Reset
REQ-024 SHALL on wrst_n low force immediately:
- state IDLE, beat count 0, grant_id 0;
- last_grant NREQ-1, so requester 0 wins first;
- fifo_winc 0, req_ready 0, busy 0.
REQ-025 SHALL abandon any in-progress burst on reset without further transfers; deassertion takes effect at the next wclk edge.

Configuration
REQ-026 SHALL support macro FIFO_WR_ARB_TAG_EN.
REQ-027 SHALL set DW=DSIZE+IDW with FIFO_WR_ARB_TAG_EN defined, fifo_wdata = {grant_id, payload}; otherwise DW=DSIZE, payload only.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, BURST=1) and an IDW width function in package fifo_arb_pkg.
REQ-029 SHALL implement the round-robin picker as sub-module rr_pick (inputs req vector, last_grant; outputs valid, index).

Verification
REQ-030 SHALL cover reset: req_valid=4'b1111 -> requester 0 granted, 4 beats; then 1, 2, 3, 0 in order.
REQ-031 SHALL cover stall: fifo_wfull high for 3 cycles at beat 2 of a burst -> no winc, no beat counted; burst completes with exactly 4 writes.
REQ-032 SHALL cover almost-full: fifo_awfull high at beat 1 -> burst ends after that beat; next grant goes to the next requester.
REQ-033 SHALL cover abandon: granted requester drops valid after 2 beats -> IDLE; last_grant updated; no extra winc.
REQ-034 SHALL cover sparse requests: only req_valid[2] high with last_grant=3 -> grant_id=2 after one cycle; with FIFO_WR_ARB_TAG_EN, fifo_wdata upper bits = 2'b10.
REQ-035 SHALL cover mid-burst reset: wrst_n low at beat 3 -> outputs zero the same cycle; after release, requester 0 wins first.
